fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Decoupling buffer between the instruction-fetch stage (PC, +1 incrementer, I-mem read) and the decode stage.
- Accepts (pc, instr) pairs from fetch and presents them in order to decode over a valid/ready handshake.
- Absorbs decode stalls and supports a single-cycle flush on branch redirect.
- Tags each entry whose PC is not the sequential successor of the previously accepted PC. Addresses are word indices, so "sequential" means pc+1.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- AW, 2, pointer width; equals log2(DEPTH).
- XLEN, 32, width of PC and instruction words.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  fetch presents a pair this cycle.
- in_ready  output  1  queue can accept a pair this cycle.
- in_pc  input  XLEN  word address of fetched instruction.
- in_instr  input  XLEN  fetched instruction word.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  XLEN  head entry PC.
- out_instr  output  XLEN  head entry instruction.
- out_redirect  output  1  head entry is non-sequential: first after reset/flush, or pc != prev_pc+1.
- flush  input  1  discard all entries; the next push starts a new stream.
- count  output  AW+1  number of valid entries.

Behaviour:
- Reset (rst=0, async):
  - Pointers and count go to 0.
  - out_valid=0, in_ready=1, out_pc=0, out_instr=0, out_redirect=0.
  - Internal first_flag=1, last_pc=0.
  - Storage contents are don't-care.
- Push: fires on in_valid && in_ready at a rising edge. Writes {pc, instr, redir} at the write pointer.
  - redir = first_flag || (in_pc != last_pc + 1), with modulo-2^XLEN add, so 0xFFFFFFFF followed by 0 counts as sequential.
  - On push: last_pc <= in_pc, first_flag <= 0.
- Pop: fires on out_valid && out_ready at a rising edge; advances the read pointer.
- Ordering is first-word-fall-through:
  - out_pc, out_instr and out_redirect are driven combinationally from the head entry.
  - An entry pushed at edge N is visible at the output during the cycle after N. Latency is 1 cycle.
- in_ready = (count != DEPTH). It does not depend on out_ready, so there is no combinational ready path through the queue.
  - When full, a pop and a refused push in the same cycle leave count=DEPTH-1.
- Simultaneous push and pop when not full or empty: count unchanged, both pointers advance.
- When empty, out_valid=0, and the output data buses hold the last read entry (don't-care for consumers).
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Flush has priority over push and pop in the same cycle. At the edge:
  - count <= 0, read and write pointers <= 0, first_flag <= 1.
  - Any coincident push or pop is ignored.
  - out_valid=0 in the following cycle, and in_ready=1.
- Flush while empty has no effect other than setting first_flag.
- Reset asserted mid-operation immediately clears out_valid and count, regardless of clk.

Decomposition:
- Shared package (fetch_pkg):
  - Constants XLEN=32 and FQ_DEPTH=4.
  - Typedef fq_entry_t {pc[XLEN-1:0], instr[XLEN-1:0], redir}.
- Optional sub-module fq_storage: DEPTH x entry register array with one write port and one async read port. Its clocked writes carry no reset.
- Control (pointers, count, first_flag, last_pc, redirect compare) stays in fetch_queue.

Test Plan:
- Reset then sequential stream:
  - Stimulus: push pc=0..3 with instr=0xA0..0xA3, out_ready=0.
  - Response: count reaches 4, in_ready=0 after the 4th push.
  - Then out_ready=1: pops 0xA0..0xA3 in order, with out_redirect=1 only on pc=0.
- Full boundary: with the queue full, hold in_valid=1 (pc=4) and out_ready=1 for one cycle.
  - Pop of pc=0 occurs, push is refused, count=3.
  - Next cycle pc=4 is accepted, with redirect=0.
- Redirect tagging:
  - Stimulus: push pc=10, 11, 20, 21.
  - Response: out_redirect sequence is 1, 0, 1, 0.
  - Wrap check: push pc=0xFFFFFFFF then 0; the second entry has redirect=0.
- Flush priority:
  - Stimulus: 3 entries queued; assert flush together with in_valid=1 (pc=50) and out_ready=1.
  - Response next cycle: count=0, out_valid=0, pc=50 not stored.
  - The following push of pc=51 presents with out_redirect=1.
- Streaming:
  - Stimulus: in_valid=1 and out_ready=1 continuously for 20 cycles.
  - Response: count stays 1 after the first push, one instruction per cycle, output pc trails input pc by exactly 1 cycle.
- Async reset mid-operation:
  - Stimulus: 2 entries queued; drive rst=0 between clock edges.
  - Response: out_valid=0 and count=0 before the next edge.
  - After release, the first push has redirect=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-to-decode path.
// Entry layout for the fetch queue.
package fetch_pkg;

  localparam int XLEN     = 32;
  localparam int FQ_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            redir;
  } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Fetch queue entry array.
// One write port, one async read port.
module fq_storage
  import fetch_pkg::*;
#(
  parameter int  DEPTH = FQ_DEPTH,
  parameter int  AW    = 2,
  parameter type T     = fq_entry_t
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  T              wdata,
  input  logic [AW-1:0] raddr,
  output T              rdata
);

  T mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode FWFT queue with redirect tagging
// and single-cycle flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            out_redirect,
  input  logic            flush,
  output logic [AW:0]     count
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            redir;
  } entry_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [XLEN-1:0] last_pc;
  logic          first_flag;
  logic          push;
  logic          pop;
  logic          redir;
  entry_t        wr_entry;
  entry_t        head;
  entry_t        hold;
  entry_t        shown;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Wrapping add: 0xFFFFFFFF -> 0 is sequential.
  assign redir = first_flag || (in_pc != last_pc + XLEN'(1));

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = in_pc;
    wr_entry.instr = in_instr;
    wr_entry.redir = redir;
  end

  fq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .T     (entry_t)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // When empty, show the last consumed entry (zero after reset).
  assign shown        = out_valid ? head : hold;
  assign out_pc       = shown.pc;
  assign out_instr    = shown.instr;
  assign out_redirect = shown.redir;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      first_flag <= 1'b1;
      last_pc    <= '0;
      hold       <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      first_flag <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + AW'(1);
        last_pc    <= in_pc;
        first_flag <= 1'b0;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold   <= head;
      end
      unique case (1'b1)
        push && !pop: count <= count + (AW+1)'(1);
        pop && !push: count <= count - (AW+1)'(1);
        default:      count <= count;
      endcase
    end
  end

endmodule
